// File: rtl/ahb_bus_arbiter_if.sv
// Bus bundle between the AHB masters, the arbiter/mux and the shared slave path.
// The master modport is the side that drives requests and address/control;
// the slave modport is the arbiter's view of the same signals.
interface ahb_bus_arbiter_if #(
   parameter int unsigned NUM_M = 2,
   parameter int unsigned AW    = 32,
   parameter int unsigned DW    = 32
);
   localparam int unsigned MW = $clog2(NUM_M);

   logic                  hready_i;
   logic [NUM_M-1:0]      m_hbusreq_i;
   logic [NUM_M-1:0]      m_hlock_i;
   logic [NUM_M-1:0]      m_hgrant_o;
   logic [2*NUM_M-1:0]    m_htrans_i;
   logic [3*NUM_M-1:0]    m_hburst_i;
   logic [3*NUM_M-1:0]    m_hsize_i;
   logic [NUM_M-1:0]      m_hwrite_i;
   logic [AW*NUM_M-1:0]   m_haddr_i;
   logic [DW*NUM_M-1:0]   m_hwdata_i;
   logic [1:0]            s_htrans_o;
   logic [2:0]            s_hburst_o;
   logic [2:0]            s_hsize_o;
   logic                  s_hwrite_o;
   logic [AW-1:0]         s_haddr_o;
   logic [DW-1:0]         s_hwdata_o;
   logic                  s_hmastlock_o;
   logic [MW-1:0]         hmaster_o;

   modport master (
      output hready_i, m_hbusreq_i, m_hlock_i, m_htrans_i, m_hburst_i,
             m_hsize_i, m_hwrite_i, m_haddr_i, m_hwdata_i,
      input  m_hgrant_o, s_htrans_o, s_hburst_o, s_hsize_o, s_hwrite_o,
             s_haddr_o, s_hwdata_o, s_hmastlock_o, hmaster_o
   );

   modport slave (
      input  hready_i, m_hbusreq_i, m_hlock_i, m_htrans_i, m_hburst_i,
             m_hsize_i, m_hwrite_i, m_haddr_i, m_hwdata_i,
      output m_hgrant_o, s_htrans_o, s_hburst_o, s_hsize_o, s_hwrite_o,
             s_haddr_o, s_hwdata_o, s_hmastlock_o, hmaster_o
   );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Classic AHB HBUSREQ/HGRANT arbiter plus master-side mux for the MiniSoC bus.
// Round-robin grant that holds through HLOCK and fixed-length bursts; the
// address/control path follows the address-phase owner, HWDATA follows the
// data-phase owner one transfer behind.
module ahb_bus_arbiter #(
   parameter int unsigned NUM_M = 2,
   parameter int unsigned DEF_M = 0,
   parameter int unsigned AW    = 32,
   parameter int unsigned DW    = 32
) (
   input  logic             hclk_i,
   input  logic             hresetn_i,
   ahb_bus_arbiter_if.slave bus
);
   localparam int unsigned MW = $clog2(NUM_M);

   typedef enum logic [1:0] {
      TR_IDLE   = 2'b00,
      TR_BUSY   = 2'b01,
      TR_NONSEQ = 2'b10,
      TR_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      BU_SINGLE = 3'd0,
      BU_INCR   = 3'd1,
      BU_WRAP4  = 3'd2,
      BU_INCR4  = 3'd3,
      BU_WRAP8  = 3'd4,
      BU_INCR8  = 3'd5,
      BU_WRAP16 = 3'd6,
      BU_INCR16 = 3'd7
   } hburst_e;

   // registered arbitration state
   logic [NUM_M-1:0] grant;
   logic [MW-1:0]    grant_idx;
   logic [MW-1:0]    hmaster;
   logic [MW-1:0]    data_owner;
   logic             mastlock;
   logic [3:0]       rem;

   // next-state helpers
   htrans_e          own_trans;
   hburst_e          own_burst;
   logic             granted_lock;
   logic [3:0]       burst_last;
   logic [3:0]       rem_new;
   logic             may_move;
   logic [MW-1:0]    next_idx;
   logic [NUM_M-1:0] next_grant;

   // mux results
   logic [1:0]       htrans_mux;
   logic [2:0]       hburst_mux;
   logic [2:0]       hsize_mux;
   logic             hwrite_mux;
   logic [AW-1:0]    haddr_mux;
   logic [DW-1:0]    hwdata_mux;

   // Pick the address-phase owner's transfer type/burst and the grant holder's lock
   always_comb begin
      own_trans    = TR_IDLE;
      own_burst    = BU_SINGLE;
      granted_lock = 1'b0;
      for (int unsigned i = 0; i < NUM_M; i++) begin
         if (hmaster == MW'(i)) begin
            own_trans = htrans_e'(bus.m_htrans_i[2*i +: 2]);
            own_burst = hburst_e'(bus.m_hburst_i[3*i +: 3]);
         end
         if (grant_idx == MW'(i)) begin
            granted_lock = bus.m_hlock_i[i];
         end
      end
   end

   // Remaining-beat count after this edge; grant may move once at most one beat remains
   always_comb begin
      case (own_burst)
         BU_WRAP4,  BU_INCR4:  burst_last = 4'd3;
         BU_WRAP8,  BU_INCR8:  burst_last = 4'd7;
         BU_WRAP16, BU_INCR16: burst_last = 4'd15;
         default:              burst_last = 4'd0;
      endcase
      rem_new = rem;
      case (own_trans)
         TR_NONSEQ: rem_new = burst_last;
         TR_SEQ:    if (rem != 4'd0) rem_new = rem - 4'd1;
         default:   rem_new = rem;
      endcase
      may_move = !granted_lock && (rem_new <= 4'd1);
   end

   // Round-robin search starting just above the current holder, holder checked last
   always_comb begin
      logic        found;
      int unsigned cand;
      next_idx = MW'(DEF_M);
      found    = 1'b0;
      for (int unsigned k = 1; k <= NUM_M; k++) begin
         cand = 32'(grant_idx) + k;
         if (cand >= NUM_M) cand = cand - NUM_M;
         for (int unsigned j = 0; j < NUM_M; j++) begin
            if (!found && (j == cand) && bus.m_hbusreq_i[j]) begin
               found    = 1'b1;
               next_idx = MW'(j);
            end
         end
      end
      for (int unsigned j = 0; j < NUM_M; j++) begin
         next_grant[j] = (next_idx == MW'(j));
      end
   end

   // Ownership, lock, beat count and grant advance only on HREADY edges
   always_ff @(posedge hclk_i) begin
      if (!hresetn_i) begin
         grant      <= NUM_M'(1) << DEF_M;
         grant_idx  <= MW'(DEF_M);
         hmaster    <= MW'(DEF_M);
         data_owner <= MW'(DEF_M);
         mastlock   <= 1'b0;
         rem        <= 4'd0;
      end else if (bus.hready_i) begin
         hmaster    <= grant_idx;
         data_owner <= hmaster;
         mastlock   <= granted_lock;
         rem        <= rem_new;
         if (may_move) begin
            grant     <= next_grant;
            grant_idx <= next_idx;
         end
      end
   end

   // Address/control by address-phase owner, write data by data-phase owner
   always_comb begin
      htrans_mux = '0;
      hburst_mux = '0;
      hsize_mux  = '0;
      hwrite_mux = 1'b0;
      haddr_mux  = '0;
      hwdata_mux = '0;
      for (int unsigned i = 0; i < NUM_M; i++) begin
         if (hmaster == MW'(i)) begin
            htrans_mux = bus.m_htrans_i[2*i +: 2];
            hburst_mux = bus.m_hburst_i[3*i +: 3];
            hsize_mux  = bus.m_hsize_i[3*i +: 3];
            hwrite_mux = bus.m_hwrite_i[i];
            haddr_mux  = bus.m_haddr_i[AW*i +: AW];
         end
         if (data_owner == MW'(i)) begin
            hwdata_mux = bus.m_hwdata_i[DW*i +: DW];
         end
      end
   end

   assign bus.m_hgrant_o    = grant;
   assign bus.hmaster_o     = hmaster;
   assign bus.s_hmastlock_o = mastlock;
   assign bus.s_htrans_o    = htrans_mux;
   assign bus.s_hburst_o    = hburst_mux;
   assign bus.s_hsize_o     = hsize_mux;
   assign bus.s_hwrite_o    = hwrite_mux;
   assign bus.s_haddr_o     = haddr_mux;
   assign bus.s_hwdata_o    = hwdata_mux;
endmodule
